// File: rtl/switch_debouncer.sv
// Per-bit synchroniser, stability-counter debouncer and edge detector for board switches and buttons.
// Each bit must hold a new level for CNT_MAX consecutive cycles at the synchroniser output before sw_db follows.
module switch_debouncer #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_MAX     = 1000000,
  parameter int CNT_W       = $clog2(CNT_MAX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] accept;

  // Plain flop chain: no logic between stages so each stage gets a full cycle to resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= sw_raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync[i] != sw_db[i]) && (cnt[i] == CNT_LAST);
    end
  end

  // Any return to the accepted level restarts the count, so partial counts never accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((sync[i] == sw_db[i]) || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_db   <= '0;
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      sw_db   <= (sw_db & ~accept) | (sync & accept);
      rise    <= accept & sync;
      fall    <= accept & ~sync;
      changed <= |accept;
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer with CNT_MAX=4: stimulus queues expected strobe events,
// a monitor pops one entry each time any strobe appears and compares edge number, level and strobes.
module tb_switch_debouncer;

  localparam int WIDTH       = 16;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_MAX     = 4;
  localparam int LAT         = SYNC_STAGES + CNT_MAX;

  typedef struct {
    int          cyc;
    logic [15:0] db;
    logic [15:0] rise;
    logic [15:0] fall;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sw_raw = '0;
  logic [15:0] sw_db, rise, fall;
  logic        changed;

  int   edge_cnt = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t q[$];

  switch_debouncer #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .CNT_MAX(CNT_MAX)
  ) dut (
    .clk(clk), .rst(rst), .sw_raw(sw_raw),
    .sw_db(sw_db), .rise(rise), .fall(fall), .changed(changed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, req, edge_cnt);
    end
  endtask

  task automatic expect_at(input int cyc, input logic [15:0] db, input logic [15:0] r,
                           input logic [15:0] f);
    exp_t e;
    e.cyc = cyc; e.db = db; e.rise = r; e.fall = f;
    q.push_back(e);
  endtask

  // Monitor: every cycle carrying a strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (changed !== 1'b0 || rise !== 16'h0 || fall !== 16'h0) begin
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_strobe: got rise=0x%h fall=0x%h changed=%b at edge %0d, expected none",
                 rise, fall, changed, edge_cnt);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("strobe_edge", edge_cnt, e.cyc);
        check("sw_db", {16'h0, sw_db}, {16'h0, e.db});
        check("rise", {16'h0, rise}, {16'h0, e.rise});
        check("fall", {16'h0, fall}, {16'h0, e.fall});
        check("changed", {31'h0, changed}, 32'd1);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic pat [9];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    // Power-up: reset held 3 edges with all switches high, then a full-latency rise on every bit.
    sw_raw = 16'hFFFF;
    rst    = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("reset_sw_db", {16'h0, sw_db}, 32'h0);
      check("reset_rise", {16'h0, rise}, 32'h0);
    end
    rst = 1'b0;
    expect_at(edge_cnt + LAT, 16'hFFFF, 16'hFFFF, 16'h0000);
    repeat (LAT + 3) @(negedge clk);

    // Clean falling step on bit 2 only.
    sw_raw = 16'hFFFB;
    expect_at(edge_cnt + LAT, 16'hFFFB, 16'h0000, 16'h0004);
    repeat (LAT + 3) @(negedge clk);

    // All remaining bits fall together.
    sw_raw = 16'h0000;
    expect_at(edge_cnt + LAT, 16'h0000, 16'h0000, 16'hFFFB);
    repeat (LAT + 3) @(negedge clk);

    // 3-cycle glitch on bit 0 (one short of CNT_MAX) must be rejected.
    sw_raw[0] = 1'b1;
    repeat (3) @(negedge clk);
    sw_raw[0] = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    check("glitch_sw_db", {16'h0, sw_db}, 32'h0);

    // Bounce on bit 3; only the final stable high run counts.
    for (int i = 0; i < 9; i++) begin
      sw_raw[3] = pat[i];
      if (i == 5) expect_at(edge_cnt + LAT, 16'h0008, 16'h0008, 16'h0000);
      @(negedge clk);
    end
    repeat (LAT + 2) @(negedge clk);

    // Two bits rising together give one shared strobe cycle.
    sw_raw[5:4] = 2'b11;
    expect_at(edge_cnt + LAT, 16'h0038, 16'h0030, 16'h0000);
    repeat (LAT + 3) @(negedge clk);

    // Bit 7 high for 4 edges, then reset discards its count; all high bits re-debounce.
    sw_raw[7] = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_sw_db", {16'h0, sw_db}, 32'h0);
    check("midreset_rise", {16'h0, rise}, 32'h0);
    rst = 1'b0;
    expect_at(edge_cnt + LAT, 16'h00B8, 16'h00B8, 16'h0000);
    repeat (LAT + 4) @(negedge clk);

    check("final_sw_db", {16'h0, sw_db}, 32'h00B8);
    check("pending_expectations", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
Per-bit synchroniser, debouncer and edge detector for the board slide switches and push-buttons. It sits directly upstream of the board top level. Raw pad inputs enter here; clean, glitch-free levels leave on sw_db and feed the logic, divider and flip-flop blocks in place of raw sw. The block also produces single-cycle rise/fall strobes for downstream counters and state machines.

Parameters:
WIDTH, 16, number of independent input bits
SYNC_STAGES, 2, flip-flop stages in each input synchroniser; must be >= 2
CNT_MAX, 1000000, consecutive stable cycles needed to accept a new level (10 ms at 100 MHz); must be >= 2; simulation uses 4
CNT_W, clog2(CNT_MAX), width of each per-bit stability counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
sw_raw  input  WIDTH  raw asynchronous switch/button pads
sw_db  output  WIDTH  debounced level per bit
rise  output  WIDTH  one-cycle strobe per bit; sw_db bit went 0->1
fall  output  WIDTH  one-cycle strobe per bit; sw_db bit went 1->0
changed  output  1  one-cycle strobe; OR-reduction of (rise | fall)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: sampled only on a clk rising edge. When asserted, all synchroniser flops = 0, sw_db = 0, all counters = 0, rise = fall = 0, changed = 0. These values are visible the cycle after the reset edge.
- Synchroniser: each bit passes through SYNC_STAGES flops. The last stage is sync[i]. There is no logic between stages.
- Per-bit counter, evaluated each rising edge (priority top-down):
  - rst: cnt <= 0.
  - sync[i] == sw_db[i]: cnt <= 0; sw_db holds.
  - cnt == CNT_MAX-1: sw_db[i] <= sync[i]; cnt <= 0; rise[i] or fall[i] <= 1 per the new value.
  - Otherwise: cnt <= cnt+1.
- Strobes: rise, fall and changed are registered and default to 0 every cycle. A strobe is high exactly in the cycle where the new sw_db value is first visible, and never for 2 consecutive cycles from one transition.
- Latency:
  - A raw level held stable is reflected on sw_db exactly SYNC_STAGES+CNT_MAX rising edges after the first edge that captures it.
  - Default simulation values (2, 4): sw_db changes after the 6th edge.
- Glitch rule (stability measured at sync[i]):
  - A level differing from sw_db for <= CNT_MAX-1 consecutive cycles is rejected. Its counter returns to 0 and no strobe fires.
  - A level differing for >= CNT_MAX cycles is accepted.
- Bounce: any return to the current sw_db value restarts that bit's count from 0. Partial counts never accumulate across bounces.
- Independence: bits share no state. Simultaneous transitions on several bits yield simultaneous strobes in the same cycle, and changed is a single pulse.
- Reset mid-count discards the count. After rst deasserts, a switch held at 1 is re-debounced from 0 and produces a rise strobe after the full latency. This power-up rise is required behaviour.
- Counter never exceeds CNT_MAX-1, so there is no wrap-around.
- Metastability is handled only by the synchroniser. sw_raw has no timing relationship to clk.

Test Plan:
1. Assert rst for 3 cycles with sw_raw = 16'hFFFF, then release. Required: sw_db = 0 and rise = 0 while rst is high. Exactly 6 edges after release, sw_db = 16'hFFFF, rise = 16'hFFFF and changed = 1 for exactly one cycle.
2. CNT_MAX=4, sw_db[0]=0. Pulse sw_raw[0] high for 3 cycles, then low. Required: sw_db[0] stays 0; rise, fall and changed stay 0 throughout.
3. Drive sw_raw[3] with the bounce pattern 1,0,1,1,0,1,1,1,1 (one value per cycle). Required: sw_db[3] rises exactly 6 edges after the final 0->1, and rise[3] pulses once.
4. Set sw_raw[5:4] from 2'b00 to 2'b11 in the same cycle. Required: both bits update in the same cycle, rise = 16'h0030, and changed is high for one cycle.
5. Hold sw_raw[7]=1, then assert rst for 1 cycle after 4 stable cycles. Required: no rise before reset, sw_db[7]=0 after reset, and rise[7] fires 6 edges after rst deasserts.
6. Take sw_db[2] from 1 back to 0 with a clean step. Required: fall[2]=1 for one cycle, rise[2]=0, and all other strobe bits stay 0.
